// File: rtl/fifo_wr_framer.sv
// rtl/fifo_wr_framer.sv - frames a valid/ready byte stream into SOF/seq/payload/checksum for the async FIFO write port
// Define FRAMER_CRC8_EN for a CRC-8 (poly 0x07) trailer; otherwise the trailer is an XOR checksum.
module fifo_wr_framer #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE    = 8'hA5,
  parameter int                    MAX_PAYLOAD = 64,
  parameter int                    LEN_WIDTH   = 7
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  fifo_full,
  output logic                  fifo_w_en,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  trunc_err,
  output logic [15:0]           frame_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_SEQ,
    ST_PAYLOAD,
    ST_TRAILER
  } state_t;

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] seq;
  logic [DATA_WIDTH-1:0] chk;
  logic [LEN_WIDTH-1:0]  cnt;
  logic                  seq_wr;
  logic                  payload_xfer;
  logic                  trailer_wr;
  logic                  trunc_hit;

  // One byte of checksum progress per write, so the trailer is ready with no extra cycle.
  function automatic logic [DATA_WIDTH-1:0] chk_next(input logic [DATA_WIDTH-1:0] acc,
                                                     input logic [DATA_WIDTH-1:0] din);
`ifdef FRAMER_CRC8_EN
    logic [DATA_WIDTH-1:0] c;
    c = acc ^ din;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      c = c[DATA_WIDTH-1] ? ((c << 1) ^ DATA_WIDTH'(8'h07)) : (c << 1);
    end
    return c;
`else
    return acc ^ din;
`endif
  endfunction

  always_comb begin
    next_state   = state;
    s_ready      = 1'b0;
    fifo_w_en    = 1'b0;
    fifo_data    = '0;
    seq_wr       = 1'b0;
    payload_xfer = 1'b0;
    trailer_wr   = 1'b0;
    trunc_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_valid) next_state = ST_SOF;
      end
      ST_SOF: begin
        fifo_w_en = !fifo_full;
        fifo_data = SOF_BYTE;
        if (!fifo_full) next_state = ST_SEQ;
      end
      ST_SEQ: begin
        fifo_w_en = !fifo_full;
        fifo_data = seq;
        seq_wr    = !fifo_full;
        if (!fifo_full) next_state = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        s_ready      = !fifo_full;
        fifo_w_en    = s_valid && !fifo_full;
        fifo_data    = s_data;
        payload_xfer = s_valid && !fifo_full;
        if (payload_xfer) begin
          if (s_last) begin
            next_state = ST_TRAILER;
          end else if (cnt == LEN_WIDTH'(MAX_PAYLOAD - 1)) begin
            // Frame is full: close it here, the remaining input opens a new frame.
            next_state = ST_TRAILER;
            trunc_hit  = 1'b1;
          end
        end
      end
      ST_TRAILER: begin
        fifo_w_en  = !fifo_full;
        fifo_data  = chk;
        trailer_wr = !fifo_full;
        if (!fifo_full) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state       <= ST_IDLE;
      seq         <= '0;
      chk         <= '0;
      cnt         <= '0;
      frame_count <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      trunc_err   <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= (next_state != ST_IDLE);
      frame_done <= trailer_wr;
      trunc_err  <= trunc_hit;
      if (seq_wr) chk <= chk_next('0, seq);
      if (payload_xfer) begin
        chk <= chk_next(chk, s_data);
        cnt <= cnt + 1'b1;
      end
      if (trailer_wr) begin
        seq         <= seq + 1'b1;
        frame_count <= frame_count + 16'd1;
        cnt         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_framer.sv
// tb/tb_fifo_wr_framer.sv - scoreboard bench for fifo_wr_framer against a packet-level reference model
module tb_fifo_wr_framer;

  localparam int MAXP = 64;

  logic        w_clk = 1'b0;
  logic        w_rst_n;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic        fifo_full;
  logic        fifo_w_en;
  logic [7:0]  fifo_data;
  logic        busy;
  logic        frame_done;
  logic        trunc_err;
  logic [15:0] frame_count;

  always #5 w_clk = ~w_clk;

  fifo_wr_framer dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .fifo_full(fifo_full), .fifo_w_en(fifo_w_en), .fifo_data(fifo_data),
    .busy(busy), .frame_done(frame_done), .trunc_err(trunc_err), .frame_count(frame_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  int m_seq = 0, m_fc = 0, m_done = 0, m_trunc = 0;
  int obs_done = 0, obs_trunc = 0, obs_ready = 0;
  bit rand_full = 0;
  bit gaps = 0;
  int stall_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] model_chk(input logic [7:0] msg[$]);
    logic [7:0] r;
    r = 8'h00;
`ifdef FRAMER_CRC8_EN
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        logic fb;
        fb = r[7] ^ msg[i][b];
        r  = {r[6:0], 1'b0};
        if (fb) r = r ^ 8'h07;
      end
    end
`else
    foreach (msg[i]) r = r ^ msg[i];
`endif
    return r;
  endfunction

  task automatic model_packet(input logic [7:0] pkt[$]);
    int i = 0;
    while (i < pkt.size()) begin
      int n;
      logic [7:0] msg[$];
      n = (pkt.size() - i > MAXP) ? MAXP : pkt.size() - i;
      msg = {};
      msg.push_back(8'(m_seq));
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(m_seq));
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(pkt[i + k]);
        msg.push_back(pkt[i + k]);
      end
      exp_q.push_back(model_chk(msg));
      if (n == MAXP && i + n < pkt.size()) m_trunc++;
      m_seq = (m_seq + 1) % 256;
      m_fc++;
      m_done++;
      i += n;
    end
  endtask

  initial begin
    forever begin
      @(negedge w_clk);
      if (w_rst_n) begin
        if (frame_done) obs_done++;
        if (trunc_err) obs_trunc++;
        if (s_ready) obs_ready++;
        if (fifo_full) check("stall_quiet_wen_ready", {30'd0, fifo_w_en, s_ready}, 32'd0);
        if (fifo_w_en) begin
          if (exp_q.size() == 0) check("exp_queue_nonempty_on_write", exp_q.size(), 1);
          else check("fifo_byte", fifo_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive_cycle(output bit acc, input bit stall_trig);
    @(negedge w_clk);
    acc = s_valid && s_ready;
    @(posedge w_clk);
    #1;
    if (acc && stall_trig) stall_left = 5;
    if (stall_left > 0) begin
      fifo_full = 1'b1;
      stall_left--;
    end else begin
      fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  endtask

  task automatic do_reset();
    w_rst_n = 1'b0;
    #1;
    check("rst_mid_s_ready", s_ready, 0);
    check("rst_mid_fifo_w_en", fifo_w_en, 0);
    check("rst_mid_fifo_data", fifo_data, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_frame_count", frame_count, 0);
    exp_q.delete();
    m_seq = 0;
    m_fc = 0;
    m_done--;
    s_valid = 1'b0;
    s_last = 1'b0;
    fifo_full = 1'b0;
    repeat (2) @(posedge w_clk);
    #1;
    w_rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] pkt[$], input int stall_idx, input int abort_idx);
    bit acc;
    int n;
    model_packet(pkt);
    foreach (pkt[i]) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          s_valid = 1'b0;
          drive_cycle(acc, 1'b0);
        end
      end
      s_valid = 1'b1;
      s_data  = pkt[i];
      s_last  = (i == pkt.size() - 1);
      acc = 1'b0;
      n = 0;
      while (!acc && n < 500) begin
        drive_cycle(acc, i == stall_idx);
        n++;
      end
      if (!acc) check("accept_timeout_cycles", n, 0);
      if (i == abort_idx) begin
        do_reset();
        return;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      drive_cycle(acc, 1'b0);
      n++;
    end
    if (n >= 500) check("drain_timeout_cycles", n, 0);
    drive_cycle(acc, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] pkt[$];
    int r0, d0, t0, f0;
    w_rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    s_last = 1'b0;
    fifo_full = 1'b0;
    repeat (3) @(posedge w_clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_fifo_w_en", fifo_w_en, 0);
    check("rst_fifo_data", fifo_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_trunc_err", trunc_err, 0);
    check("rst_frame_count", frame_count, 0);
    w_rst_n = 1'b1;

    d0 = obs_done;
    pkt = '{8'h01};
    send(pkt, -1, -1);
    check("t1_frame_count", frame_count, 1);
    check("t1_done_pulses", obs_done - d0, 1);

    r0 = obs_ready;
    pkt = '{8'h01, 8'h02, 8'h04};
    send(pkt, -1, -1);
    check("t2_ready_cycles", obs_ready - r0, 3);

    pkt = '{8'h01, 8'h02, 8'h04};
    send(pkt, 1, -1);

    t0 = obs_trunc;
    f0 = m_fc;
    pkt = {};
    for (int i = 0; i < 66; i++) pkt.push_back(8'($urandom));
    send(pkt, -1, -1);
    check("t4_trunc_pulses", obs_trunc - t0, 1);
    check("t4_frame_count", frame_count, m_fc);
    check("t4_frames_added", m_fc - f0, 2);

    for (int i = 0; i < 256; i++) begin
      pkt = {};
      pkt.push_back(8'($urandom));
      send(pkt, -1, -1);
    end
    check("t5_frame_count", frame_count, m_fc);

    rand_full = 1'b1;
    gaps = 1'b1;
    for (int p = 0; p < 30; p++) begin
      pkt = {};
      for (int i = 0; i < $urandom_range(1, 140); i++) pkt.push_back(8'($urandom));
      send(pkt, -1, -1);
    end
    rand_full = 1'b0;
    gaps = 1'b0;
    check("rand_frame_count", frame_count, m_fc);
    check("rand_done_pulses", obs_done, m_done);
    check("rand_trunc_pulses", obs_trunc, m_trunc);

    pkt = {};
    for (int i = 0; i < 10; i++) pkt.push_back(8'($urandom));
    send(pkt, -1, 3);
    pkt = '{8'h5A, 8'hC3};
    send(pkt, -1, -1);
    check("t6_frame_count", frame_count, 1);
    check("final_done_pulses", obs_done, m_done);
    check("final_trunc_pulses", obs_trunc, m_trunc);
    check("final_exp_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
